// File: rtl/winner_banner_overlay.sv
// winner_banner_overlay
// Overlays the end-of-game banner "PLAYER n WINS" (5x5-block font) on the
// incoming VGA pixel stream. Two pipeline stages: S1 decodes the pixel
// coordinate into banner cell/glyph position, S2 looks up the font and muxes
// the output colour. All timing signals are delayed by the same two cycles.
//
// Ports
//   pclk, rst                  pixel clock, synchronous active-high reset
//   hcount_in, vcount_in       pixel coordinate of the incoming pixel
//   hsync_in .. vblnk_in       timing from the previous stage
//   rgb_in                     background pixel
//   show                       level request to display the banner
//   winner                     0-based winner index (digit shown = winner+1)
//   hsync_out .. vblnk_out     timing delayed by 2 cycles
//   rgb_out                    composited pixel aligned with delayed timing
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | banner not requested, stream passes through
// ON    | banner drawn this frame
// OFF   | banner requested but in the dark half of a blink period
module winner_banner_overlay #(
  parameter int          SQUARE_LOG2  = 3,
  parameter int          ORIGIN_H     = 204,
  parameter int          ORIGIN_V     = 364,
  parameter int          PLAYER_W     = 1,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter bit          TRANSPARENT  = 1'b1,
  parameter int          BLINK_FRAMES = 0
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [10:0]         hcount_in,
  input  logic [10:0]         vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [11:0]         rgb_in,
  input  logic                show,
  input  logic [PLAYER_W-1:0] winner,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [11:0]         rgb_out
);

  localparam int BOX_COLS = 77;  // 13 cells * 6 blocks, minus trailing gap
  localparam int BOX_ROWS = 5;
  localparam int CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t              state;
  logic [PLAYER_W-1:0] winner_lat;
  logic [CNT_W-1:0]    frame_cnt;
  logic                vblnk_prev;
  logic                frame_start;

  // Font: row 0 in bits [24:20], leftmost column is the MSB of each row.
  // Codes: 0 space, 1..9 digits, 10..19 = P L A Y E R W I N S.
  function automatic logic [24:0] font(input logic [4:0] code);
    case (code)
      5'd1:  font = {5'b11000, 5'b01000, 5'b01000, 5'b01000, 5'b11100};
      5'd2:  font = {5'b11110, 5'b00001, 5'b01110, 5'b10000, 5'b11111};
      5'd3:  font = {5'b11110, 5'b00001, 5'b01110, 5'b00001, 5'b11110};
      5'd4:  font = {5'b10010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      5'd5:  font = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b11110};
      5'd6:  font = {5'b01110, 5'b10000, 5'b11110, 5'b10001, 5'b01110};
      5'd7:  font = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b00100};
      5'd8:  font = {5'b01110, 5'b10001, 5'b01110, 5'b10001, 5'b01110};
      5'd9:  font = {5'b01110, 5'b10001, 5'b01111, 5'b00001, 5'b01110};
      5'd10: font = {5'b11110, 5'b10001, 5'b11110, 5'b10000, 5'b10000};
      5'd11: font = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
      5'd12: font = {5'b01110, 5'b10001, 5'b11111, 5'b10001, 5'b10001};
      5'd13: font = {5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100};
      5'd14: font = {5'b11111, 5'b10000, 5'b11110, 5'b10000, 5'b11111};
      5'd15: font = {5'b11110, 5'b10001, 5'b11110, 5'b10100, 5'b10010};
      5'd16: font = {5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b01010};
      5'd17: font = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b11111};
      5'd18: font = {5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001};
      5'd19: font = {5'b01111, 5'b10000, 5'b01110, 5'b00001, 5'b11110};
      default: font = '0;
    endcase
  endfunction

  // ---------------- S1: coordinate decode ----------------
  // Unsigned subtraction: pixels left of / above the origin wrap to huge
  // block indices and therefore fall outside the box compare.
  logic [10:0] dh, dv, block_col, block_row;
  logic        in_box_d;

  always_comb begin
    dh        = hcount_in - 11'(ORIGIN_H);
    dv        = vcount_in - 11'(ORIGIN_V);
    block_col = dh >> SQUARE_LOG2;
    block_row = dv >> SQUARE_LOG2;
    in_box_d  = (block_col < 11'(BOX_COLS)) && (block_row < 11'(BOX_ROWS));
  end

  logic        in_box_s1;
  logic [3:0]  char_s1;
  logic [2:0]  col_s1;
  logic [2:0]  row_s1;
  logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [11:0] rgb_s1;

  always_ff @(posedge pclk) begin
    if (rst) begin
      in_box_s1 <= 1'b0;
      char_s1   <= '0;
      col_s1    <= '0;
      row_s1    <= '0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
    end else begin
      in_box_s1 <= in_box_d;
      // Only meaningful inside the box (block_col < 77 fits in 7 bits).
      char_s1   <= 4'(block_col[6:0] / 7'd6);
      col_s1    <= 3'(block_col[6:0] % 7'd6);
      row_s1    <= 3'(block_row);
      hsync_s1  <= hsync_in;
      vsync_s1  <= vsync_in;
      hblnk_s1  <= hblnk_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= rgb_in;
    end
  end

  // ---------------- frame-synchronous control ----------------
  assign frame_start = vblnk_in & ~vblnk_prev;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= IDLE;
      winner_lat <= '0;
      frame_cnt  <= '0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (frame_start) begin
        case (state)
          IDLE: begin
            if (show) begin
              state      <= ON;
              winner_lat <= winner;
              frame_cnt  <= '0;
            end
          end
          default: begin
            if (!show) begin
              state <= IDLE;
            end else if (BLINK_FRAMES > 0) begin
              if (32'(frame_cnt) + 32'd1 == 32'(BLINK_FRAMES)) begin
                state     <= (state == ON) ? OFF : ON;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // ---------------- S2: font lookup + mux ----------------
  logic [4:0]  char_code;
  logic [24:0] glyph;
  logic [4:0]  row_bits;
  logic [7:0]  row_pad;
  logic        glyph_on;

  always_comb begin
    case (char_s1)
      4'd0:    char_code = 5'd10;
      4'd1:    char_code = 5'd11;
      4'd2:    char_code = 5'd12;
      4'd3:    char_code = 5'd13;
      4'd4:    char_code = 5'd14;
      4'd5:    char_code = 5'd15;
      4'd7:    char_code = 5'(winner_lat) + 5'd1;
      4'd9:    char_code = 5'd16;
      4'd10:   char_code = 5'd17;
      4'd11:   char_code = 5'd18;
      4'd12:   char_code = 5'd19;
      default: char_code = 5'd0;
    endcase
    glyph = font(char_code);
    case (row_s1)
      3'd0:    row_bits = glyph[24:20];
      3'd1:    row_bits = glyph[19:15];
      3'd2:    row_bits = glyph[14:10];
      3'd3:    row_bits = glyph[9:5];
      3'd4:    row_bits = glyph[4:0];
      default: row_bits = '0;
    endcase
    // Glyph column 5 lands on the zero pad bit, which draws the inter-cell gap.
    row_pad  = {2'b00, row_bits, 1'b0};
    glyph_on = in_box_s1 && row_pad[3'd5 - col_s1];
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      hblnk_out <= 1'b0;
      vblnk_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= hsync_s1;
      vsync_out <= vsync_s1;
      hblnk_out <= hblnk_s1;
      vblnk_out <= vblnk_s1;
      if (hblnk_s1 || vblnk_s1)
        rgb_out <= 12'h000;
      else if (state == ON && glyph_on)
        rgb_out <= FG_COLOR;
      else if (state == ON && in_box_s1 && !TRANSPARENT)
        rgb_out <= BG_COLOR;
      else
        rgb_out <= rgb_s1;
    end
  end

endmodule

// File: tb/tb_winner_banner_overlay.sv
module tb_winner_banner_overlay;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        show = 1'b0;
  logic [0:0]  winner = '0;

  logic        hs_a, vs_a, hb_a, vb_a, hs_b, vs_b, hb_b, vb_b, hs_c, vs_c, hb_c, vb_c;
  logic [11:0] rgb_a, rgb_b, rgb_c;

  always #5 pclk = ~pclk;

  winner_banner_overlay dut_a (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .show(show), .winner(winner),
    .hsync_out(hs_a), .vsync_out(vs_a), .hblnk_out(hb_a), .vblnk_out(vb_a), .rgb_out(rgb_a));

  winner_banner_overlay #(.TRANSPARENT(1'b0), .BG_COLOR(12'h0A5)) dut_b (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .show(show), .winner(winner),
    .hsync_out(hs_b), .vsync_out(vs_b), .hblnk_out(hb_b), .vblnk_out(vb_b), .rgb_out(rgb_b));

  winner_banner_overlay #(.BLINK_FRAMES(2)) dut_c (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .show(show), .winner(winner),
    .hsync_out(hs_c), .vsync_out(vs_c), .hblnk_out(hb_c), .vblnk_out(vb_c), .rgb_out(rgb_c));

  int n_pass = 0;
  int n_total = 0;
  int n_printed = 0;

  // ---------------- behavioural model ----------------
  localparam int OH = 204;
  localparam int OV = 364;
  int          blink_cfg [3] = '{0, 0, 2};
  bit          transp_cfg[3] = '{1'b1, 1'b0, 1'b1};
  logic [11:0] bg_cfg    [3] = '{12'h000, 12'h0A5, 12'h000};

  bit active[3];
  int nframes[3];
  int digit[3];
  logic [15:0] exp_o[3];
  bit   valid = 1'b0;
  bit   p_rst = 1'b1;
  int   p_h, p_v;
  bit   p_hs, p_vs, p_hb, p_vb;
  logic [11:0] p_rgb;
  string txt = "PLAYER ? WINS";

  function automatic string glyph(byte c);
    case (c)
      "P": return {"####.", "#...#", "####.", "#....", "#...."};
      "L": return {"#....", "#....", "#....", "#....", "#####"};
      "A": return {".###.", "#...#", "#####", "#...#", "#...#"};
      "Y": return {"#...#", ".#.#.", "..#..", "..#..", "..#.."};
      "E": return {"#####", "#....", "####.", "#....", "#####"};
      "R": return {"####.", "#...#", "####.", "#.#..", "#..#."};
      "W": return {"#...#", "#...#", "#.#.#", "#.#.#", ".#.#."};
      "I": return {"#####", "..#..", "..#..", "..#..", "#####"};
      "N": return {"#...#", "##..#", "#.#.#", "#..##", "#...#"};
      "S": return {".####", "#....", ".###.", "....#", "####."};
      "1": return {"##...", ".#...", ".#...", ".#...", "###.."};
      "2": return {"####.", "....#", ".###.", "#....", "#####"};
      "3": return {"####.", "....#", ".###.", "....#", "####."};
      "4": return {"#..#.", "#..#.", "#####", "...#.", "...#."};
      "5": return {"#####", "#....", "####.", "....#", "####."};
      "6": return {".###.", "#....", "####.", "#...#", ".###."};
      "7": return {"#####", "....#", "...#.", "..#..", "..#.."};
      "8": return {".###.", "#...#", ".###.", "#...#", ".###."};
      "9": return {".###.", "#...#", ".####", "....#", ".###."};
      default: return {".....", ".....", ".....", ".....", "....."};
    endcase
  endfunction

  function automatic bit visible(int k);
    if (!active[k]) return 1'b0;
    if (blink_cfg[k] == 0) return 1'b1;
    return ((nframes[k] / blink_cfg[k]) % 2) == 0;
  endfunction

  function automatic logic [11:0] model_pix(int k, int h, int v, bit hb, bit vb, logic [11:0] rgb);
    int bc, br, ci, gc;
    byte c;
    string g;
    if (hb || vb) return 12'h000;
    if (!visible(k)) return rgb;
    if (h < OH || v < OV) return rgb;
    bc = (h - OH) / 8;
    br = (v - OV) / 8;
    if (bc >= 77 || br >= 5) return rgb;
    ci = bc / 6;
    gc = bc % 6;
    if (gc < 5) begin
      c = txt[ci];
      if (c == "?") c = byte'(8'h30 + digit[k]);
      g = glyph(c);
      if (g[br * 5 + gc] == "#") return 12'hFFF;
    end
    return transp_cfg[k] ? rgb : bg_cfg[k];
  endfunction

  always @(posedge pclk) begin
    bit fs;
    for (int k = 0; k < 3; k++) begin
      if (rst || p_rst) exp_o[k] = 16'h0000;
      else exp_o[k] = {p_hs, p_vs, p_hb, p_vb, model_pix(k, p_h, p_v, p_hb, p_vb, p_rgb)};
    end
    fs = !rst && vblnk_in && !(p_rst ? 1'b0 : p_vb);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        active[k] = 1'b0; nframes[k] = 0; digit[k] = 1;
      end else if (fs) begin
        if (!active[k]) begin
          if (show) begin active[k] = 1'b1; nframes[k] = 0; digit[k] = int'(winner) + 1; end
        end else if (!show) begin
          active[k] = 1'b0;
        end else begin
          nframes[k]++;
        end
      end
    end
    p_h = int'(hcount_in); p_v = int'(vcount_in);
    p_hs = hsync_in; p_vs = vsync_in; p_hb = hblnk_in; p_vb = vblnk_in;
    p_rgb = rgb_in; p_rst = rst;
    valid = 1'b1;
  end

  function automatic logic [15:0] dut_out(int k);
    case (k)
      0: return {hs_a, vs_a, hb_a, vb_a, rgb_a};
      1: return {hs_b, vs_b, hb_b, vb_b, rgb_b};
      default: return {hs_c, vs_c, hb_c, vb_c, rgb_c};
    endcase
  endfunction

  always @(negedge pclk) begin
    if (valid) begin
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (dut_out(k) === exp_o[k]) n_pass++;
        else begin
          if (n_printed < 20)
            $display("FAIL stream dut%0d t=%0t got %h expected %h", k, $time, dut_out(k), exp_o[k]);
          n_printed++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [11:0] ramp = 12'h001;
  logic [7:0]  tick = '0;
  int rows[10] = '{360, 363, 364, 370, 380, 390, 400, 403, 404, 410};

  task automatic check(string name, logic [15:0] act, logic [15:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else begin
      $display("FAIL %s got %h expected %h", name, act, expv);
      n_printed++;
    end
  endtask

  task automatic px(int h, int v, bit hb, bit vb);
    @(negedge pclk);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb;
    hsync_in = tick[2]; vsync_in = tick[6];
    rgb_in = ramp;
    ramp = ramp + 12'd37;
    tick = tick + 8'd1;
  endtask

  task automatic new_frame();
    for (int i = 0; i < 4; i++) px(0, 0, 1'b1, 1'b1);
  endtask

  task automatic scan();
    foreach (rows[r]) begin
      for (int h = 200; h <= 824; h += 4) px(h, rows[r], 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) px(1000, rows[r], 1'b1, 1'b0);
    end
  endtask

  task automatic probe(string name, int h, int v, bit hb, logic [11:0] rgb,
                       logic [11:0] ea, logic [11:0] eb, logic [11:0] ec);
    @(negedge pclk);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    rgb_in = rgb;
    @(negedge pclk);
    @(negedge pclk);
    check({name, "_a"}, {4'h0, rgb_a}, {4'h0, ea});
    check({name, "_b"}, {4'h0, rgb_b}, {4'h0, eb});
    check({name, "_c"}, {4'h0, rgb_c}, {4'h0, ec});
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    check("reset_a", dut_out(0), 16'h0000);
    check("reset_b", dut_out(1), 16'h0000);
    check("reset_c", dut_out(2), 16'h0000);
    rst = 1'b0;

    // pass-through while banner not requested
    new_frame(); scan();
    new_frame(); scan();
    probe("idle_pass", 204, 364, 1'b0, 12'h123, 12'h123, 12'h123, 12'h123);

    // banner on, winner 0 -> digit '1'
    show = 1'b1; winner = 1'b0;
    new_frame();
    probe("p_corner",   204, 364, 1'b0, 12'h123, 12'hFFF, 12'hFFF, 12'hFFF);
    probe("gap",        244, 364, 1'b0, 12'h456, 12'h456, 12'h0A5, 12'h456);
    probe("one_stem",   548, 380, 1'b0, 12'h789, 12'hFFF, 12'hFFF, 12'hFFF);
    probe("past_box",   820, 364, 1'b0, 12'h321, 12'h321, 12'h321, 12'h321);
    probe("hblank",     204, 364, 1'b1, 12'h123, 12'h000, 12'h000, 12'h000);
    probe("one_r0c3",   564, 364, 1'b0, 12'h111, 12'h111, 12'h0A5, 12'h111);
    scan();
    show = 1'b0;          // mid-frame toggle must not tear
    scan();
    probe("mid_toggle", 204, 364, 1'b0, 12'h123, 12'hFFF, 12'hFFF, 12'hFFF);
    show = 1'b1;

    // winner change while shown is ignored
    winner = 1'b1;
    new_frame();
    probe("keep_digit", 564, 364, 1'b0, 12'h111, 12'h111, 12'h0A5, 12'h111);
    scan();

    // blink phases on dut_c: frames 3,4 off, 5 on
    new_frame();
    probe("blink_off",  204, 364, 1'b0, 12'h123, 12'hFFF, 12'hFFF, 12'h123);
    probe("blink_gap",  244, 364, 1'b0, 12'h456, 12'h456, 12'h0A5, 12'h456);
    scan();
    new_frame(); scan();
    new_frame();
    probe("blink_on",   204, 364, 1'b0, 12'h123, 12'hFFF, 12'hFFF, 12'hFFF);
    scan();

    // drop show -> idle; re-raise -> new winner latched
    show = 1'b0;
    new_frame();
    probe("hide",       204, 364, 1'b0, 12'h123, 12'h123, 12'h123, 12'h123);
    probe("hide_gap",   244, 364, 1'b0, 12'h456, 12'h456, 12'h456, 12'h456);
    scan();
    show = 1'b1;
    new_frame();
    probe("two_r0c3",   564, 364, 1'b0, 12'h111, 12'hFFF, 12'hFFF, 12'hFFF);
    scan();

    // reset pulse mid-banner
    @(negedge pclk);
    hcount_in = 11'd204; vcount_in = 11'd364; hblnk_in = 1'b0; vblnk_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = 12'h123; rst = 1'b1;
    @(negedge pclk);
    check("rst_mid_a", dut_out(0), 16'h0000);
    check("rst_mid_b", dut_out(1), 16'h0000);
    check("rst_mid_c", dut_out(2), 16'h0000);
    rst = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("rst_idle_a", {4'h0, rgb_a}, 16'h0123);
    check("rst_idle_b", {4'h0, rgb_b}, 16'h0123);
    check("rst_idle_c", {4'h0, rgb_c}, 16'h0123);
    scan();
    new_frame();
    probe("rst_reon",   204, 364, 1'b0, 12'h123, 12'hFFF, 12'hFFF, 12'hFFF);
    probe("rst_digit",  564, 364, 1'b0, 12'h111, 12'hFFF, 12'hFFF, 12'hFFF);
    scan();

    repeat (4) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
